fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, single-cycle pulse that begins execution at start_addr.
REQ-004 SHALL have port start_addr, input, 8, first PC value on start.
REQ-005 SHALL have port stall, input, 1, hold PC and state for this cycle (multi-cycle memory op).
REQ-006 SHALL have ports branch, jump and halt, input, 1 each, decoded control flags for the current instruction.
REQ-007 SHALL have port cond, input, 1, branch condition from ALU; 1 = taken.
REQ-008 SHALL have port br_offset, input, 8, signed two's-complement PC-relative branch offset.
REQ-009 SHALL have port jump_target, input, 8, absolute jump destination.
REQ-010 SHALL have port imem_addr, output, 8, instruction memory address; always equal to pc.
REQ-011 SHALL have port imem_data, input, 9, combinational instruction memory read data.
REQ-012 SHALL have ports instr, output, 9, and instr_valid, output, 1; instr = imem_data, instr_valid = 1 only in RUN.
REQ-013 SHALL have port done, output, 1, high while in HALTED.
REQ-014 SHALL have port instr_count, output, 16, count of retired instructions.

Function
REQ-015 SHALL implement states IDLE, RUN and HALTED.
REQ-016 IDLE: start=1 SHALL load pc<=start_addr and go to RUN next cycle; otherwise SHALL hold.
REQ-017 RUN with stall=1 SHALL hold pc, state and instr_count.
REQ-018 RUN with stall=0 SHALL select next pc with priority halt > jump > (branch & cond) > sequential.
REQ-019 halt SHALL hold pc and go to HALTED.
REQ-020 jump SHALL set pc<=jump_target.
REQ-021 A taken branch SHALL set pc<=pc+sign_extend(br_offset), modulo 256; branch with cond=0 SHALL be sequential.
REQ-022 Sequential flow SHALL set pc<=pc+1, wrapping from 255 to 0.
REQ-023 Every RUN cycle with stall=0 SHALL increment instr_count by 1, including the halt instruction; the count SHALL wrap at 65535 to 0.
REQ-024 start SHALL be ignored in RUN.
REQ-025 In HALTED, start=1 SHALL load pc<=start_addr, clear instr_count and go to RUN; otherwise SHALL hold.
REQ-026 branch, jump and halt SHALL be ignored outside RUN.
REQ-027 Latency: the new pc SHALL be visible on imem_addr one cycle after the deciding edge; there SHALL be no delay slot.

Reset
REQ-028 Reset SHALL force state=IDLE, pc=0, instr_count=0, done=0 and instr_valid=0 on the next edge.
REQ-029 Reset SHALL override start, stall and all control inputs in the same cycle, including mid-RUN.

Configuration
REQ-030 With FETCH_CYCLE_COUNT_EN defined, SHALL add output cycle_count, 16, which counts every RUN cycle including stalled cycles, is cleared by reset and restart, and wraps.
REQ-031 Without FETCH_CYCLE_COUNT_EN, the port and its counter SHALL be absent.

Structure
REQ-032 Package fetch_pkg SHALL hold PC_W=8, INSTR_W=9, CNT_W=16 and the state enum type.
REQ-033 Next-PC selection SHALL be in sub-module next_pc (combinational: pc, flags, offset, target -> pc_next); the FSM and counters SHALL be in fetch_unit.

Verification
REQ-034 Bench SHALL cover: reset, then start with start_addr=0x10, 4 cycles with no flags -> imem_addr 0x10, 0x11, 0x12, 0x13, 0x14; instr_count=4.
REQ-035 Bench SHALL cover: at pc=0x20, branch=1, cond=1, br_offset=0xFC -> pc=0x1C; the same with cond=0 -> pc=0x21.
REQ-036 Bench SHALL cover: at pc=0x30, jump=1, branch=1, cond=1, jump_target=0x80 -> pc=0x80; at pc=0xFF, sequential -> pc=0x00.
REQ-037 Bench SHALL cover: stall=1 for 3 cycles at pc=0x05 -> pc stays 0x05 and instr_count is unchanged; with FETCH_CYCLE_COUNT_EN, cycle_count advances by 3.
REQ-038 Bench SHALL cover: halt=1 at pc=0x07 -> pc stays 0x07, done=1 and instr_valid=0; start with start_addr=0x00 -> RUN at 0x00 with instr_count=0.
REQ-039 Bench SHALL cover: reset asserted mid-RUN at pc=0x42 -> next cycle IDLE, pc=0 and instr_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths and the fetch state type for the fetch unit slice.
// Imported by next_pc and fetch_unit; no ports.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_t;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // Sign-extending PC-relative add; the carry out is dropped,
  // so the result wraps modulo 2**PC_W.
  function automatic pc_t pc_rel(input pc_t base, input pc_t ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// next_pc: combinational next-PC select, halt > jump > taken branch > pc+1.
// Ports: pc, branch, cond, jump, halt, br_offset, jump_target in; pc_next out.
module next_pc
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            branch,
  input  logic            cond,
  input  logic            jump,
  input  logic            halt,
  input  logic [PC_W-1:0] br_offset,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc_next
);

  logic taken;

  assign taken = branch & cond;

  // Flags may overlap, so the first match wins.
  always_comb begin
    pc_next = pc + PC_W'(1);
    priority case (1'b1)
      halt:    pc_next = pc;
      jump:    pc_next = jump_target;
      taken:   pc_next = pc_rel(pc, br_offset);
      default: pc_next = pc + PC_W'(1);
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/RUN/HALTED PC sequencer with retired-instruction counter.
// Ports: clk, reset, start, start_addr, stall, branch, jump, halt, cond,
//   br_offset, jump_target, imem_data in; imem_addr, instr, instr_valid,
//   done, instr_count out. FETCH_CYCLE_COUNT_EN adds cycle_count out.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic               stall,
  input  logic               branch,
  input  logic               jump,
  input  logic               halt,
  input  logic               cond,
  input  logic [PC_W-1:0]    br_offset,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               done,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic [CNT_W-1:0]   cycle_count,
`endif
  output logic [CNT_W-1:0]   instr_count
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;

  next_pc u_next_pc (
    .pc          (pc),
    .branch      (branch),
    .cond        (cond),
    .jump        (jump),
    .halt        (halt),
    .br_offset   (br_offset),
    .jump_target (jump_target),
    .pc_next     (pc_next)
  );

  assign imem_addr = pc;
  assign instr     = imem_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_count <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            pc          <= start_addr;
            instr_count <= '0;
            instr_valid <= 1'b1;
          end
        end
        S_RUN: begin
          // A stall freezes everything, including a pending halt.
          if (!stall) begin
            pc          <= pc_next;
            instr_count <= instr_count + CNT_W'(1);
            if (halt) begin
              state       <= S_HALTED;
              instr_valid <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          if (start) begin
            state       <= S_RUN;
            pc          <= start_addr;
            instr_count <= '0;
            instr_valid <= 1'b1;
            done        <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  // Counts every RUN cycle, stalled or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state == S_RUN) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end else if (start) begin
      cycle_count <= '0;
    end
  end
`endif

endmodule
